// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: operand sequencer for the iterative CORDIC core.
// Accepts one float32 operand, hands it to the unpacker, captures the unpacked
// angle/sign/special flag, then strobes the single-stage datapath ITERS times
// before presenting the result over a valid/ready handshake.
module cordic_iter_ctrl #(
  parameter int ITERS = 16,
  parameter int IW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic [31:0]   unp_data,
  input  logic [31:0]   unp_result,
  input  logic          unp_sign,
  input  logic          unp_special,
  output logic          dp_load,
  output logic          dp_en,
  output logic [IW-1:0] dp_iter,
  output logic [31:0]   dp_angle,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic          out_special,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);
  localparam logic [IW-1:0] ITER_ONE  = IW'(1);
  localparam logic [IW-1:0] ITER_ZERO = IW'(0);

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_in_ready,    w_in_ready_nxt;
  logic [31:0]   r_unp_data,    w_unp_data_nxt;
  logic          r_dp_en,       w_dp_en_nxt;
  logic [IW-1:0] r_dp_iter,     w_dp_iter_nxt;
  logic [31:0]   r_dp_angle,    w_dp_angle_nxt;
  logic          r_out_valid,   w_out_valid_nxt;
  logic          r_out_sign,    w_out_sign_nxt;
  logic          r_out_special, w_out_special_nxt;
  logic          r_busy,        w_busy_nxt;
  logic          w_dp_load;

  // Next-state logic and next values of every output register
  always_comb begin
    w_state_nxt       = r_state;
    w_in_ready_nxt    = r_in_ready;
    w_unp_data_nxt    = r_unp_data;
    w_dp_en_nxt       = r_dp_en;
    w_dp_iter_nxt     = r_dp_iter;
    w_dp_angle_nxt    = r_dp_angle;
    w_out_valid_nxt   = r_out_valid;
    w_out_sign_nxt    = r_out_sign;
    w_out_special_nxt = r_out_special;
    w_dp_load         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt    = S_LOAD;
          w_unp_data_nxt = in_data;
          w_in_ready_nxt = 1'b0;
        end else begin
          w_in_ready_nxt = 1'b1;
        end
      end

      S_LOAD: begin
        w_dp_angle_nxt    = unp_result;
        w_out_sign_nxt    = unp_sign;
        w_out_special_nxt = unp_special;
        if (unp_special) begin
          // Out-of-range operand: skip the datapath entirely
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
        end else begin
          // The special flag only exists once the operand sits in unp_data,
          // so the load strobe is decoded from the LOAD state and that flag.
          w_dp_load     = 1'b1;
          w_dp_iter_nxt = ITER_ZERO;
          w_dp_en_nxt   = 1'b1;
          w_state_nxt   = S_RUN;
        end
      end

      S_RUN: begin
        if (r_dp_iter == LAST_ITER) begin
          // dp_iter is left at the final index while the result is held
          w_state_nxt     = S_DONE;
          w_dp_en_nxt     = 1'b0;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_dp_iter_nxt = r_dp_iter + ITER_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_state_nxt       = S_IDLE;
          w_out_valid_nxt   = 1'b0;
          w_out_sign_nxt    = 1'b0;
          w_out_special_nxt = 1'b0;
          w_dp_iter_nxt     = ITER_ZERO;
          w_in_ready_nxt    = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_dp_en_nxt     = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready    <= 1'b1;
      r_unp_data    <= 32'h0000_0000;
      r_dp_en       <= 1'b0;
      r_dp_iter     <= ITER_ZERO;
      r_dp_angle    <= 32'h0000_0000;
      r_out_valid   <= 1'b0;
      r_out_sign    <= 1'b0;
      r_out_special <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_in_ready    <= w_in_ready_nxt;
      r_unp_data    <= w_unp_data_nxt;
      r_dp_en       <= w_dp_en_nxt;
      r_dp_iter     <= w_dp_iter_nxt;
      r_dp_angle    <= w_dp_angle_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_sign    <= w_out_sign_nxt;
      r_out_special <= w_out_special_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign unp_data    = r_unp_data;
  assign dp_load     = w_dp_load;
  assign dp_en       = r_dp_en;
  assign dp_iter     = r_dp_iter;
  assign dp_angle    = r_dp_angle;
  assign out_valid   = r_out_valid;
  assign out_sign    = r_out_sign;
  assign out_special = r_out_special;
  assign busy        = r_busy;

endmodule
